ext_data_memory: RTL and testbench



---
 rtl/ext_data_memory.sv | 100 ++++++++++
 tb/tb_ext_data_memory.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_data_memory.sv
// Behavioural external data-memory responder: one 256-bit line per request,
// fixed LATENCY edges from acceptance to a single-cycle ack.
module ext_data_memory #(
  parameter int MEM_LINES = 512,
  parameter int LATENCY   = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  input  logic         enable_i,
  input  logic         write_i,
  output logic [255:0] data_o,
  output logic         ack_o
);

  localparam int IDX_W = $clog2(MEM_LINES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t             state_r;
  logic [7:0]         cnt_r;
  logic [IDX_W-1:0]   idx_r;
  logic               wr_r;
  logic [255:0]       wdata_r;
  logic [255:0]       mem_r [MEM_LINES];

  logic               access_s;
  logic [IDX_W-1:0]   req_idx_s;
  logic               unused_s;

  assign req_idx_s = addr_i[IDX_W+4:5];
  assign unused_s  = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

  // Access edge: the wait counter has run out while a request is pending.
  always_comb begin
    access_s = 1'b0;
    if ((state_r == ST_WAIT) && (cnt_r == 8'd0)) begin
      access_s = 1'b1;
    end else begin
      access_s = 1'b0;
    end
  end

  // Request FSM; every request passes through WAIT so LATENCY=1 still
  // acks exactly one edge after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      idx_r   <= '0;
      wr_r    <= 1'b0;
      wdata_r <= 256'd0;
      data_o  <= 256'd0;
      ack_o   <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (enable_i) begin
            idx_r   <= req_idx_s;
            wr_r    <= write_i;
            wdata_r <= data_i;
            cnt_r   <= 8'(LATENCY - 1);
            state_r <= ST_WAIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (access_s) begin
            state_r <= ST_ACK;
            ack_o   <= 1'b1;
            data_o  <= wr_r ? wdata_r : mem_r[idx_r];
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        ST_ACK: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Line storage is deliberately not reset; a reset during WAIT suppresses the write.
  always_ff @(posedge clk) begin
    if (access_s && wr_r && !rst) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

endmodule

// File: tb/tb_ext_data_memory.sv
// Self-checking bench for ext_data_memory: randomized transactions against
// an associative-array line model, plus reset, wrap and back-to-back cases.
module tb_ext_data_memory;

  logic         clk = 1'b0;
  logic         rst, rst1;
  logic [31:0]  addr, addr1;
  logic [255:0] wdata, wdata1, rdata, rdata1;
  logic         en, en1, we, we1, ack, ack1;

  int tests_run = 0;
  int tests_failed = 0;
  logic [255:0] ref_mem [int];

  always #5 clk = ~clk;

  ext_data_memory #(.MEM_LINES(512), .LATENCY(10)) dut (
    .clk(clk), .rst(rst), .addr_i(addr), .data_i(wdata), .enable_i(en),
    .write_i(we), .data_o(rdata), .ack_o(ack)
  );

  ext_data_memory #(.MEM_LINES(16), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst1), .addr_i(addr1), .data_i(wdata1), .enable_i(en1),
    .write_i(we1), .data_o(rdata1), .ack_o(ack1)
  );

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32'd32) % 32'd512);
  endfunction

  // Issue one request; two edges after acceptance swap in other inputs while enable stays high.
  task automatic run_txn(input logic wr, input logic [31:0] a, input logic [255:0] d,
                         input logic [31:0] alt_a, output logic [255:0] rd,
                         output int lat, output logic ack_next);
    @(negedge clk);
    en = 1'b1; we = wr; addr = a; wdata = d;
    lat = -1; rd = 256'd0; ack_next = 1'b1;
    for (int j = 0; j < 300 && lat < 0; j++) begin
      @(negedge clk);
      if (j == 2) begin addr = alt_a; wdata = rand256(); we = ~wr; end
      if (j == 4) en = 1'b0;
      if (ack === 1'b1) begin lat = j; rd = rdata; end
    end
    if (lat >= 0) begin
      @(negedge clk);
      ack_next = ack;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst1 = 1'b1;
    en = 1'b0; we = 1'b0; addr = 32'd0; wdata = 256'd0;
    en1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wdata1 = 256'd0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (ack !== 1'b0 || rdata !== 256'd0) begin
      tests_failed++;
      $display("FAIL reset_main: ack=%b data=%h expected ack=0 data=0", ack, rdata);
    end
    tests_run++;
    if (ack1 !== 1'b0 || rdata1 !== 256'd0) begin
      tests_failed++;
      $display("FAIL reset_lat1: ack=%b data=%h expected ack=0 data=0", ack1, rdata1);
    end
    rst = 1'b0; rst1 = 1'b0;
  endtask

  task automatic test_reset_then_read();
    logic [255:0] rd; int lat; logic an;
    logic [255:0] pat;
    pat = {32{8'hA5}};
    run_txn(1'b1, 32'h60, pat, $urandom, rd, lat, an);
    ref_mem[3] = pat;
    tests_run++;
    if (lat !== 10 || rd !== pat) begin
      tests_failed++;
      $display("FAIL preload_write: lat=%0d echo=%h expected lat=10 echo=%h", lat, rd, pat);
    end
    run_txn(1'b0, 32'h60, rand256(), $urandom, rd, lat, an);
    tests_run++;
    if (lat !== 10) begin
      tests_failed++;
      $display("FAIL read_latency: got %0d expected 10", lat);
    end
    tests_run++;
    if (an !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_width: ack after pulse=%b expected 0", an);
    end
    tests_run++;
    if (rd !== ref_mem[3]) begin
      tests_failed++;
      $display("FAIL read_line3: got %h expected %h", rd, ref_mem[3]);
    end
  endtask

  task automatic test_write_then_read();
    logic [255:0] rd; int lat; logic an;
    logic [255:0] pat;
    pat = {8{32'h12345678}};
    run_txn(1'b1, 32'h20, pat, $urandom, rd, lat, an);
    ref_mem[1] = pat;
    tests_run++;
    if (rd !== pat || an !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_echo: got %h ack_next=%b expected %h ack_next=0", rd, an, pat);
    end
    run_txn(1'b0, 32'h20, rand256(), $urandom, rd, lat, an);
    tests_run++;
    if (rd !== pat || lat !== 10) begin
      tests_failed++;
      $display("FAIL write_readback: got %h lat=%0d expected %h lat=10", rd, lat, pat);
    end
  endtask

  task automatic test_input_change();
    logic [255:0] rd; int lat; logic an;
    for (int l = 5; l <= 6; l++) begin
      ref_mem[l] = rand256();
      run_txn(1'b1, 32'(l * 32), ref_mem[l], $urandom, rd, lat, an);
    end
    run_txn(1'b0, 32'hA0, rand256(), 32'hC0, rd, lat, an);
    tests_run++;
    if (rd !== ref_mem[5] || lat !== 10) begin
      tests_failed++;
      $display("FAIL change_in_wait: got %h lat=%0d expected %h lat=10", rd, lat, ref_mem[5]);
    end
    run_txn(1'b0, 32'hC0, rand256(), $urandom, rd, lat, an);
    tests_run++;
    if (rd !== ref_mem[6]) begin
      tests_failed++;
      $display("FAIL line6_untouched: got %h expected %h", rd, ref_mem[6]);
    end
  endtask

  task automatic test_wrap();
    logic [255:0] rd; int lat; logic an;
    run_txn(1'b1, 32'h4000, 256'hDEAD, $urandom, rd, lat, an);
    ref_mem[line_of(32'h4000)] = 256'hDEAD;
    run_txn(1'b0, 32'h0, rand256(), $urandom, rd, lat, an);
    tests_run++;
    if (rd !== 256'hDEAD) begin
      tests_failed++;
      $display("FAIL wrap_alias: got %h expected %h", rd, 256'hDEAD);
    end
  endtask

  task automatic test_random();
    logic [255:0] rd, d; int lat; logic an;
    int pool [6] = '{3, 1, 5, 100, 101, 511};
    int ln; logic wr; logic [31:0] a;
    for (int n = 0; n < 12; n++) begin
      ln = pool[$urandom_range(0, 5)];
      a  = ($urandom & 32'hFFFF_C000) | 32'(ln * 32) | ($urandom & 32'h1F);
      wr = ($urandom_range(0, 1) == 1) || !ref_mem.exists(ln);
      d  = rand256();
      run_txn(wr, a, d, $urandom, rd, lat, an);
      if (wr) ref_mem[ln] = d;
      tests_run++;
      if (rd !== ref_mem[ln] || lat !== 10 || an !== 1'b0) begin
        tests_failed++;
        $display("FAIL random_%0d: addr=%h got %h lat=%0d expected %h lat=10",
                 n, a, rd, lat, ref_mem[ln]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [255:0] rd; int lat; logic an; logic seen;
    run_txn(1'b1, 32'hE0, 256'd0, $urandom, rd, lat, an);
    ref_mem[7] = 256'd0;
    seen = 1'b0;
    @(negedge clk);
    en = 1'b1; we = 1'b1; addr = 32'hE0; wdata = 256'hFF;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (j == 0) en = 1'b0;
      if (ack === 1'b1) seen = 1'b1;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (ack !== 1'b0 || rdata !== 256'd0) begin
      tests_failed++;
      $display("FAIL abort_state: ack=%b data=%h expected ack=0 data=0", ack, rdata);
    end
    rst = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (ack === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_ack: ack seen=%b expected 0", seen);
    end
    run_txn(1'b0, 32'hE0, rand256(), $urandom, rd, lat, an);
    tests_run++;
    if (rd !== ref_mem[7]) begin
      tests_failed++;
      $display("FAIL abort_no_write: got %h expected %h", rd, ref_mem[7]);
    end
  endtask

  task automatic test_reset_in_ack();
    logic [255:0] rd, d; int lat; logic an; logic got;
    d = rand256();
    got = 1'b0;
    @(negedge clk);
    en = 1'b1; we = 1'b1; addr = 32'h120; wdata = d;
    for (int j = 0; j < 300 && !got; j++) begin
      @(negedge clk);
      if (j == 0) en = 1'b0;
      if (ack === 1'b1) got = 1'b1;
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (got !== 1'b1 || ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_async_drop: ack_seen=%b ack_now=%b expected 1 and 0", got, ack);
    end
    @(negedge clk);
    rst = 1'b0;
    ref_mem[9] = d;
    run_txn(1'b0, 32'h120, rand256(), $urandom, rd, lat, an);
    tests_run++;
    if (rd !== ref_mem[9]) begin
      tests_failed++;
      $display("FAIL write_kept: got %h expected %h", rd, ref_mem[9]);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] d;
    logic exp_ack;
    d = rand256();
    for (int ph = 0; ph < 2; ph++) begin
      @(negedge clk);
      en1 = 1'b1; we1 = (ph == 0); addr1 = 32'h40; wdata1 = (ph == 0) ? d : rand256();
      for (int j = 0; j < 12; j++) begin
        @(negedge clk);
        exp_ack = (j % 3 == 1);
        tests_run++;
        if (ack1 !== exp_ack || (exp_ack && rdata1 !== d)) begin
          tests_failed++;
          $display("FAIL b2b_ph%0d_cyc%0d: ack=%b data=%h expected ack=%b data=%h",
                   ph, j, ack1, rdata1, exp_ack, d);
        end
      end
      en1 = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_then_read();
    test_write_then_read();
    test_input_change();
    test_wrap();
    test_random();
    test_reset_mid_write();
    test_reset_in_ack();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
